// File: rtl/p2p_rx_gate.sv
// Per-port CMAC rx gate: forwards or discards whole packets under block_rx,
// with wrap-around pass/drop/error packet counters and a passed-byte counter.
module p2p_rx_gate #(
  parameter int DATA_W     = 512,
  parameter int BYTE_CNT_W = 48
) (
  input  logic                  cmac_clk,
  input  logic                  cmac_rst,
  input  logic                  block_rx,
  input  logic                  cnt_clear,
  input  logic                  s_axis_tvalid,
  input  logic [DATA_W-1:0]     s_axis_tdata,
  input  logic [DATA_W/8-1:0]   s_axis_tkeep,
  input  logic                  s_axis_tlast,
  input  logic                  s_axis_tuser_err,
  output logic                  m_axis_tvalid,
  output logic [DATA_W-1:0]     m_axis_tdata,
  output logic [DATA_W/8-1:0]   m_axis_tkeep,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tuser_err,
  output logic [31:0]           pass_pkts,
  output logic [31:0]           drop_pkts,
  output logic [31:0]           err_pkts,
  output logic [BYTE_CNT_W-1:0] pass_bytes,
  output logic                  in_packet
);

  localparam int KEEP_W = DATA_W / 8;

  typedef enum logic [1:0] {IDLE, PASS, DROP} state_t;

  state_t state;
  logic   fwd;
  logic   drop;

  function automatic logic [BYTE_CNT_W-1:0] popcount(input logic [KEEP_W-1:0] k);
    logic [BYTE_CNT_W-1:0] sum;
    sum = '0;
    for (int unsigned i = 0; i < KEEP_W; i++) begin
      sum = sum + BYTE_CNT_W'(k[i]);
    end
    return sum;
  endfunction

  // block_rx only matters on the first beat of a packet (IDLE state).
  always_comb begin
    fwd  = 1'b0;
    drop = 1'b0;
    if (s_axis_tvalid) begin
      case (state)
        IDLE:    begin fwd = !block_rx; drop = block_rx; end
        PASS:    fwd  = 1'b1;
        DROP:    drop = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge cmac_clk) begin
    if (cmac_rst) begin
      state            <= IDLE;
      m_axis_tvalid    <= 1'b0;
      m_axis_tdata     <= '0;
      m_axis_tkeep     <= '0;
      m_axis_tlast     <= 1'b0;
      m_axis_tuser_err <= 1'b0;
    end else begin
      m_axis_tvalid    <= fwd;
      m_axis_tdata     <= fwd ? s_axis_tdata : '0;
      m_axis_tkeep     <= fwd ? s_axis_tkeep : '0;
      m_axis_tlast     <= fwd & s_axis_tlast;
      m_axis_tuser_err <= fwd & s_axis_tuser_err;
      if (s_axis_tvalid) begin
        case (state)
          IDLE:      if (!s_axis_tlast) state <= block_rx ? DROP : PASS;
          PASS, DROP: if (s_axis_tlast) state <= IDLE;
          default:   state <= IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge cmac_clk) begin
    if (cmac_rst || cnt_clear) begin
      pass_pkts  <= '0;
      drop_pkts  <= '0;
      err_pkts   <= '0;
      pass_bytes <= '0;
    end else begin
      if (fwd)                                      pass_bytes <= pass_bytes + popcount(s_axis_tkeep);
      if (fwd && s_axis_tlast)                      pass_pkts  <= pass_pkts + 32'd1;
      if (fwd && s_axis_tlast && s_axis_tuser_err)  err_pkts   <= err_pkts + 32'd1;
      if (drop && s_axis_tlast)                     drop_pkts  <= drop_pkts + 32'd1;
    end
  end

  assign in_packet = (state != IDLE);

endmodule

// File: tb/tb_p2p_rx_gate.sv
// Directed self-checking bench for p2p_rx_gate; the byte counter is narrowed
// to 8 bits so its wrap-around is reachable in a few beats.
module tb_p2p_rx_gate;

  localparam int DATA_W = 512;
  localparam int KEEP_W = DATA_W / 8;
  localparam int BCW    = 8;

  logic              cmac_clk = 1'b0;
  logic              cmac_rst, block_rx, cnt_clear;
  logic              s_tvalid, s_tlast, s_terr;
  logic [DATA_W-1:0] s_tdata;
  logic [KEEP_W-1:0] s_tkeep;
  logic              m_tvalid, m_tlast, m_terr;
  logic [DATA_W-1:0] m_tdata;
  logic [KEEP_W-1:0] m_tkeep;
  logic [31:0]       pass_pkts, drop_pkts, err_pkts;
  logic [BCW-1:0]    pass_bytes;
  logic              in_packet;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 cmac_clk = ~cmac_clk;

  p2p_rx_gate #(.DATA_W(DATA_W), .BYTE_CNT_W(BCW)) dut (
    .cmac_clk(cmac_clk), .cmac_rst(cmac_rst), .block_rx(block_rx), .cnt_clear(cnt_clear),
    .s_axis_tvalid(s_tvalid), .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep),
    .s_axis_tlast(s_tlast), .s_axis_tuser_err(s_terr),
    .m_axis_tvalid(m_tvalid), .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep),
    .m_axis_tlast(m_tlast), .m_axis_tuser_err(m_terr),
    .pass_pkts(pass_pkts), .drop_pkts(drop_pkts), .err_pkts(err_pkts),
    .pass_bytes(pass_bytes), .in_packet(in_packet)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Present one input cycle, then wait past the edge so outputs show its result.
  task automatic cyc(input logic v, input logic [63:0] d, input logic [KEEP_W-1:0] k,
                     input logic l, input logic e);
    s_tvalid = v;
    s_tdata  = {d, 384'h0, d};
    s_tkeep  = k;
    s_tlast  = l;
    s_terr   = e;
    @(posedge cmac_clk);
    #1;
  endtask

  task automatic idle();
    cyc(1'b0, 64'h0, '0, 1'b0, 1'b0);
  endtask

  task automatic clear_cnt();
    cnt_clear = 1'b1;
    idle();
    cnt_clear = 1'b0;
  endtask

  initial begin
    logic [KEEP_W-1:0] ones;
    ones      = '1;
    cmac_rst  = 1'b1;
    block_rx  = 1'b0;
    cnt_clear = 1'b0;
    cyc(1'b1, 64'hDEAD, ones, 1'b1, 1'b1);
    idle();
    check("rst_tvalid", m_tvalid, 0);
    check("rst_tdata", m_tdata[63:0], 0);
    check("rst_tkeep", m_tkeep, 0);
    check("rst_pass_pkts", pass_pkts, 0);
    check("rst_pass_bytes", pass_bytes, 0);
    check("rst_in_packet", in_packet, 0);
    cmac_rst = 1'b0;
    idle();

    // Pass-through
    cyc(1'b1, 64'h1, ones, 1'b1, 1'b0);
    check("pt_tvalid", m_tvalid, 1);
    check("pt_tdata", m_tdata[63:0], 1);
    check("pt_tdata_hi", m_tdata[511:448], 1);
    check("pt_tlast", m_tlast, 1);
    check("pt_pass_pkts", pass_pkts, 1);
    check("pt_pass_bytes", pass_bytes, 64);
    check("pt_in_packet", in_packet, 0);
    idle();
    check("pt_gap_tvalid", m_tvalid, 0);
    check("pt_gap_tdata", m_tdata[63:0], 0);
    clear_cnt();
    check("clr_pass_pkts", pass_pkts, 0);

    // Block: 3-beat packet dropped
    block_rx = 1'b1;
    cyc(1'b1, 64'h21, ones, 1'b0, 1'b0);
    check("blk_b1_tvalid", m_tvalid, 0);
    check("blk_b1_in_packet", in_packet, 1);
    cyc(1'b1, 64'h22, ones, 1'b0, 1'b0);
    check("blk_b2_tvalid", m_tvalid, 0);
    check("blk_b2_in_packet", in_packet, 1);
    cyc(1'b1, 64'h23, ones, 1'b1, 1'b1);
    check("blk_b3_tvalid", m_tvalid, 0);
    check("blk_b3_tdata", m_tdata[63:0], 0);
    check("blk_in_packet_end", in_packet, 0);
    check("blk_drop_pkts", drop_pkts, 1);
    check("blk_pass_pkts", pass_pkts, 0);
    check("blk_err_pkts", err_pkts, 0);
    clear_cnt();

    // Mid-packet toggle, start passing
    block_rx = 1'b0;
    cyc(1'b1, 64'h31, ones, 1'b0, 1'b0);
    check("tgl_b1_tvalid", m_tvalid, 1);
    cyc(1'b1, 64'h32, ones, 1'b0, 1'b0);
    check("tgl_b2_tdata", m_tdata[63:0], 64'h32);
    block_rx = 1'b1;
    cyc(1'b1, 64'h33, ones, 1'b0, 1'b0);
    check("tgl_b3_tvalid", m_tvalid, 1);
    cyc(1'b1, 64'h34, ones, 1'b1, 1'b0);
    check("tgl_b4_tvalid", m_tvalid, 1);
    check("tgl_b4_tdata", m_tdata[63:0], 64'h34);
    check("tgl_pass_pkts", pass_pkts, 1);
    cyc(1'b1, 64'h35, ones, 1'b1, 1'b0);
    check("tgl_next_tvalid", m_tvalid, 0);
    check("tgl_next_drop", drop_pkts, 1);
    check("tgl_next_pass", pass_pkts, 1);
    clear_cnt();

    // Mid-packet toggle, start blocked
    block_rx = 1'b1;
    cyc(1'b1, 64'h41, ones, 1'b0, 1'b0);
    check("rtg_b1_tvalid", m_tvalid, 0);
    block_rx = 1'b0;
    cyc(1'b1, 64'h42, ones, 1'b0, 1'b0);
    check("rtg_b2_tvalid", m_tvalid, 0);
    cyc(1'b1, 64'h43, ones, 1'b0, 1'b0);
    check("rtg_b3_tvalid", m_tvalid, 0);
    cyc(1'b1, 64'h44, ones, 1'b1, 1'b0);
    check("rtg_b4_tvalid", m_tvalid, 0);
    check("rtg_drop_pkts", drop_pkts, 1);
    check("rtg_pass_pkts", pass_pkts, 0);
    check("rtg_pass_bytes", pass_bytes, 0);
    clear_cnt();

    // Gaps, partial tkeep, error flag
    cyc(1'b1, 64'h51, ones, 1'b0, 1'b0);
    check("gap_b1_tvalid", m_tvalid, 1);
    check("gap_b1_tdata", m_tdata[63:0], 64'h51);
    idle();
    check("gap_hole_tvalid", m_tvalid, 0);
    check("gap_hole_in_packet", in_packet, 1);
    idle();
    cyc(1'b1, 64'h52, 64'h0000_0000_0000_00FF, 1'b1, 1'b1);
    check("gap_b2_tvalid", m_tvalid, 1);
    check("gap_b2_tkeep", m_tkeep, 64'hFF);
    check("gap_b2_tuser_err", m_terr, 1);
    check("gap_pass_bytes", pass_bytes, 72);
    check("gap_err_pkts", err_pkts, 1);
    check("gap_pass_pkts", pass_pkts, 1);
    idle();
    check("gap_after_terr", m_terr, 0);

    // Clear collides with a forwarded tlast beat
    cnt_clear = 1'b1;
    cyc(1'b1, 64'h61, ones, 1'b1, 1'b1);
    cnt_clear = 1'b0;
    check("col_tvalid", m_tvalid, 1);
    check("col_pass_pkts", pass_pkts, 0);
    check("col_pass_bytes", pass_bytes, 0);
    check("col_err_pkts", err_pkts, 0);

    // Byte counter wraps modulo 2^8
    for (int i = 0; i < 3; i++) cyc(1'b1, 64'h70, ones, 1'b1, 1'b0);
    check("wrap_bytes_192", pass_bytes, 192);
    cyc(1'b1, 64'h71, ones, 1'b1, 1'b0);
    check("wrap_bytes_0", pass_bytes, 0);
    check("wrap_pass_pkts", pass_pkts, 4);
    cyc(1'b1, 64'h72, 64'h7, 1'b1, 1'b0);
    check("wrap_bytes_3", pass_bytes, 3);
    clear_cnt();

    // Reset in the middle of a passing packet
    block_rx = 1'b0;
    cyc(1'b1, 64'h81, ones, 1'b0, 1'b0);
    check("rmp_b1_tvalid", m_tvalid, 1);
    cmac_rst = 1'b1;
    cyc(1'b1, 64'h82, ones, 1'b0, 1'b0);
    cmac_rst = 1'b0;
    check("rmp_rst_tvalid", m_tvalid, 0);
    check("rmp_rst_tdata", m_tdata[63:0], 0);
    check("rmp_rst_in_packet", in_packet, 0);
    check("rmp_rst_pass_bytes", pass_bytes, 0);
    block_rx = 1'b1;
    cyc(1'b1, 64'h83, ones, 1'b1, 1'b0);
    check("rmp_b3_tvalid", m_tvalid, 0);
    check("rmp_drop_pkts", drop_pkts, 1);
    check("rmp_pass_pkts", pass_pkts, 0);
    check("rmp_in_packet", in_packet, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
